energy_data_tx: RTL and testbench
=================================

ENERGY_DATA_TX -- requirements
Module: energy_data_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..1023.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sample_in  input  8  converted energy sample to transmit.
REQ-007 sample_valid  input  1  sample_in is offered this cycle.
REQ-008 sample_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-010 tx  output  1  serial line; idles high.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 overflow  output  1  sticky flag: a sample was offered while the FIFO was full.
REQ-013 fifo_count  output  3  FIFO occupancy, 0..4.

Function
REQ-014 The 4-entry FIFO SHALL accept sample_in on an edge where sample_valid=1 and sample_ready=1.
REQ-015 sample_ready SHALL be (fifo_count<4), from registered state only; there is no full-FIFO bypass.
REQ-016 sample_valid=1 with sample_ready=0 SHALL drop the sample and set overflow on that edge.
REQ-017 clr_ovf=1 SHALL clear overflow on the next edge; a simultaneous set wins over the clear.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with busy=1 in every state except IDLE.
REQ-019 IDLE -> START when fifo_count>0: pop the head entry into the shift register on that edge; tx=0 from that edge.
REQ-020 START -> DATA, DATA -> PARITY (or STOP when PARITY_EN=0), PARITY -> STOP: each transition after exactly CLKS_PER_BIT cycles in the state.
REQ-021 DATA SHALL send 8 bits, LSB first, each for CLKS_PER_BIT cycles.
REQ-022 The parity bit SHALL be the XOR of the 8 data bits (even parity); the stop bit SHALL be 1.
REQ-023 At the end of STOP: if fifo_count>0, pop and enter START on the same edge, with no idle cycle; else go to IDLE.
REQ-024 Push and pop on the same edge SHALL leave fifo_count unchanged and keep FIFO order.
REQ-025 FIFO read/write pointers SHALL be 2 bits and wrap modulo 4.
REQ-026 Latency, sample into an idle block with empty FIFO: accepted at edge N, popped at edge N+1, tx falls after edge N+1.
REQ-027 Frame length: (10+PARITY_EN)*CLKS_PER_BIT cycles, start edge to end of stop bit.
REQ-028 tx, busy and overflow SHALL be registered outputs (glitch-free).

Reset
REQ-029 rst_n=0 SHALL immediately force: tx=1, busy=0, overflow=0, fifo_count=0, sample_ready=0, FSM=IDLE, pointers=0, bit and cycle counters=0.
REQ-030 Reset mid-frame SHALL abort the frame, with tx high at once and FIFO contents discarded.
REQ-031 After rst_n deasserts, sample_ready SHALL be 1 from the first rising edge.

Verification (CLKS_PER_BIT=4, PARITY_EN=1, 44 cycles/frame)
REQ-032 Push 0x32 into idle block -> tx after 1 cycle = 0 | 0,1,0,0,1,1,0,0 | parity 1 | stop 1, 4 cycles each; busy=1 for 44 cycles.
REQ-033 Push 0x32, 0x5A, 0xC8 back-to-back -> three contiguous frames, no idle gap; parity bits 1, 0, 1; fifo_count peaks at 2.
REQ-034 Push 6 samples on consecutive cycles while idle -> first 5 accepted, 6th gives sample_ready=0 and sets overflow.
REQ-035 With overflow=1, assert clr_ovf one cycle -> overflow=0 next edge; with a coincident overflowing push, overflow stays 1.
REQ-036 Assert rst_n=0 during DATA bit 3 of 0x5A with 2 samples queued -> tx=1, busy=0, fifo_count=0 immediately; no further frames after release.
REQ-037 PARITY_EN=0, push 0xFF -> 40-cycle frame: start 0, eight 1s, stop 1.

Source files
------------

// File: rtl/energy_data_tx.sv
// Energy-sample serial transmitter: 4-entry FIFO feeding a UART-style framer
// (start, 8 data bits LSB first, optional even parity, stop).
module energy_data_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] fifo_count
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [9:0] LAST_CYC = 10'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [9:0]  cyc_q, cyc_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        rdy_en_q;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [4];

  logic push, pop, bit_end;

  // Ready is held low during reset and rises on the first edge after release.
  assign sample_ready = rdy_en_q && (count_q != 3'd4);
  assign push         = sample_valid && sample_ready;
  assign bit_end      = (cyc_q == LAST_CYC);

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    cyc_d   = (state_q == IDLE || bit_end) ? 10'd0 : cyc_q + 10'd1;

    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      par_d   = ^mem_q[rd_ptr_q];
    end

    // Line level is computed for the state being entered so tx is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);

    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    // A refused sample sets the flag even if a clear arrives on the same edge.
    if (sample_valid && !sample_ready) ovf_d = 1'b1;
    else if (clr_ovf)                  ovf_d = 1'b0;
    else                               ovf_d = ovf_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_energy_data_tx.sv
// Directed bench for energy_data_tx with CLKS_PER_BIT=4; a second instance
// with parity disabled shares the stimulus for the 40-cycle frame case.
module tb_energy_data_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       clr_ovf = 1'b0;

  logic       sample_ready, tx, busy, overflow;
  logic [2:0] fifo_count;
  logic       np_ready, np_tx, np_busy, np_overflow;
  logic [2:0] np_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  energy_data_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .clr_ovf(clr_ovf), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  energy_data_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(np_ready), .clr_ovf(clr_ovf), .tx(np_tx), .busy(np_busy),
    .overflow(np_overflow), .fifo_count(np_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for frame sample idx (4 samples per bit, 11 bits).
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    int b;
    b = idx / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at the negedge after the accepting edge; skip = samples already consumed.
  task automatic expect_frame(input logic [7:0] d, input int skip, input string tag);
    for (int idx = skip; idx < 44; idx++) begin
      @(negedge clk);
      check(tag, {30'd0, busy, tx}, {30'd0, 1'b1, frame_bit(d, idx)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_valid = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, sample_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, sample_ready}, 32'd1);

    // Single frame 0x32
    sample_in = 8'h32; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("single_count", {29'd0, fifo_count}, 32'd1);
    check("single_tx_pre", {30'd0, busy, tx}, 32'b01);
    expect_frame(8'h32, 0, "frame_32");
    @(negedge clk);
    check("single_idle", {30'd0, busy, tx}, 32'b01);

    // Three back-to-back frames
    sample_in = 8'h32; sample_valid = 1'b1;
    @(negedge clk);
    sample_in = 8'h5A;
    @(negedge clk);
    sample_in = 8'hC8;
    check("b2b_count1", {29'd0, fifo_count}, 32'd1);
    @(negedge clk);
    sample_valid = 1'b0;
    check("b2b_count_peak", {29'd0, fifo_count}, 32'd2);
    expect_frame(8'h32, 2, "b2b_32");
    expect_frame(8'h5A, 0, "b2b_5A");
    expect_frame(8'hC8, 0, "b2b_C8");
    @(negedge clk);
    check("b2b_idle", {29'd0, busy, tx, 1'b0}, 32'b010);
    check("b2b_empty", {29'd0, fifo_count}, 32'd0);

    // Overflow: six consecutive offers while idle
    sample_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample_in = 8'(i + 1);
      @(negedge clk);
      if (i < 4) check($sformatf("ovf_ready_%0d", i), {31'd0, sample_ready}, 32'd1);
    end
    sample_valid = 1'b0;
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_full", {29'd0, fifo_count}, 32'd4);
    check("ovf_ready_low", {31'd0, sample_ready}, 32'd0);

    // Clear, then set-beats-clear
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    sample_valid = 1'b1;
    @(negedge clk);
    check("ovf_reset_again", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    check("set_beats_clr", {31'd0, overflow}, 32'd1);
    sample_valid = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_alone", {31'd0, overflow}, 32'd0);

    // Reset during DATA bit 3 of 0x5A with two queued
    do_reset();
    @(negedge clk);
    sample_in = 8'h5A; sample_valid = 1'b1;
    @(negedge clk);
    sample_in = 8'h11;
    @(negedge clk);
    sample_in = 8'h22;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_bit3", {30'd0, busy, tx}, 32'b11);
    check("mid_queued", {29'd0, fifo_count}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {29'd0, fifo_count}, 32'd0);
    check("abort_ready", {31'd0, sample_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, sample_ready}, 32'd1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("no_frames", {29'd0, busy, tx, 1'b0}, 32'b010);
    end

    // Parity disabled: 0xFF frame of 40 cycles; parity instance runs 44
    sample_in = 8'hFF; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int idx = 0; idx < 44; idx++) begin
      @(negedge clk);
      check("np_frame", {30'd0, np_busy, np_tx},
            (idx < 40) ? {30'd0, 1'b1, (idx >= 4)} : 32'b01);
      check("p_frame_FF", {30'd0, busy, tx}, {30'd0, 1'b1, frame_bit(8'hFF, idx)});
    end
    @(negedge clk);
    check("p_idle_FF", {30'd0, busy, tx}, 32'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
